prediction_scorer: RTL
======================

# prediction_scorer

Hardware scoreboard downstream of the MLP wrapper. It consumes each predicted `label`/`ready` pair, fetches the matching ground-truth label from an external synchronous label ROM, and keeps correct and wrong counts. After the last test case it computes integer accuracy in percent with a sequential divider, then asserts `done`. This moves the pass/fail bookkeeping that the simulation bench does into synthesizable logic, so the full-dataset check also runs on hardware.

## Interface
- `number_of_test_cases`, 750: test cases per run (N); must be ≥ 1.
- `clog2_number_of_test_cases`, 10: width of index and count registers; 2^w ≥ N+1.
- `clog2_size_of_output_layer`, 4: label width (L).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `clk_en`  in  1  global enable; when 0 every register, including the edge detector, holds.
- `pred_label`  in  L  predicted label from the MLP wrapper.
- `pred_valid`  in  1  MLP `ready`, a level signal; only its rising edge counts.
- `exp_addr`  out  clog2_tc  ROM address, driven directly from the `index` register.
- `exp_label`  in  L  ROM data; valid one cycle after `exp_addr` changes.
- `correct_count`  out  clog2_tc  matches so far.
- `wrong_count`  out  clog2_tc  mismatches so far.
- `mismatch`  out  1  one-cycle pulse per wrong prediction.
- `overrun`  out  1  sticky; set when a prediction is dropped.
- `accuracy`  out  7  floor(100·correct/N); valid when `done` = 1.
- `done`  out  1  high from end of division until reset.

## Operation
- Reset (`rst` = 0 at an edge) clears everything: state IDLE, `index` 0, both counts 0, `mismatch` 0, `overrun` 0, `accuracy` 0, `done` 0, edge register `pv_d` 0. Reset applies in any state, including mid-division, and takes priority over `clk_en`.
- Edge detect: `accept` = `pred_valid` & ~`pv_d` & `clk_en`. `pv_d` ← `pred_valid` on every enabled edge.
- The FSM has five states: IDLE, WAIT, CMP, DIV, DONE.
  - **IDLE:** on `accept`, capture `pred_q` ← `pred_label` and go to WAIT.
  - **WAIT:** one cycle, which guarantees ROM latency; go to CMP.
  - **CMP:**
    - Compare `pred_q` with `exp_label` over the full L bits.
    - On equal, increment `correct_count`; otherwise increment `wrong_count` and pulse `mismatch`.
    - If `index` = N−1, go to DIV and load `rem` ← `correct_count_next`·100, computed as shifts and adds (c<<6)+(c<<5)+(c<<2), width clog2_tc+7, with `q` ← 0.
    - Otherwise `index`++ and return to IDLE.
  - **DIV:** if `rem` ≥ N, then `rem` −= N and `q`++. Otherwise set `accuracy` ← `q` and `done` ← 1, then go to DONE.
  - **DONE:** hold all outputs. `pred_valid` edges are ignored and do not set `overrun`.
- A rising edge of `pred_valid` while in WAIT, CMP or DIV drops that prediction and sets `overrun`; it is not counted.
- Invariant: `correct_count` + `wrong_count` = number of CMP cycles executed. In DONE both sum to N.
- `index` never wraps. It stops at N−1; the exit to DIV replaces the increment.

## Timing
- Accept at edge E0, meaning IDLE sees a rising edge. State is WAIT after E0, CMP after E1; counts and `mismatch` update at E2, and the block is back in IDLE after E2.
- Minimum spacing between accepted predictions is 3 enabled cycles.
- `exp_addr` changes only at the CMP edge. The ROM therefore has at least the IDLE+WAIT cycles to settle before the next compare.
- `mismatch` is high for exactly the one cycle after E2, or longer if `clk_en` drops, since it is held.
- Division takes `accuracy`+1 enabled cycles, at most 101. `done` rises at the edge after the final DIV cycle.
- With `clk_en` = 0 held through a `pred_valid` rise, the edge is seen on the first enabled edge, because `pv_d` was frozen.

## Test plan
- **All correct, N=4 override:** ROM {3,1,4,1} and predictions 3,1,4,1 → `correct_count`=4, `wrong_count`=0, no `mismatch`, `accuracy`=100, `done` within 101 cycles of the last CMP.
- **Mixed, N=4:** ROM {3,1,4,1} and predictions 3,2,4,0 → `mismatch` pulses on the 2nd and 4th predictions, counts 2/2, `accuracy`=50.
- **Floor rounding, N=3:** 2 correct out of 3 → `accuracy`=66 after 67 DIV cycles. 0 correct → `accuracy`=0 after 1 DIV cycle.
- **Overrun:** raise `pred_valid` for a second edge one cycle after an accept → `overrun`=1, only one compare happens, and `index` advances by 1.
- **Level input and enable:** hold `pred_valid` high for 10 cycles → exactly one prediction counted. Drop `clk_en` for 5 cycles mid-WAIT → state and outputs frozen, then the sequence resumes.
- **Reset mid-DIV:** assert `rst`=0 during DIV at default N=750 → after the next edge all outputs are 0 and the FSM is in IDLE. A full 750-case rerun then reproduces the bench's ACR value exactly.

Source files
------------

// File: rtl/prediction_scorer.sv
// Scoreboard for MLP predictions: compares each accepted label against a
// synchronous label ROM, counts hits/misses and divides out percent accuracy.
module prediction_scorer #(
  parameter int number_of_test_cases       = 750,
  parameter int clog2_number_of_test_cases = 10,
  parameter int clog2_size_of_output_layer = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic [clog2_size_of_output_layer-1:0] pred_label,
  input  logic                                  pred_valid,
  output logic [clog2_number_of_test_cases-1:0] exp_addr,
  input  logic [clog2_size_of_output_layer-1:0] exp_label,
  output logic [clog2_number_of_test_cases-1:0] correct_count,
  output logic [clog2_number_of_test_cases-1:0] wrong_count,
  output logic                                  mismatch,
  output logic                                  overrun,
  output logic [6:0]                            accuracy,
  output logic                                  done
);
  localparam int CW = clog2_number_of_test_cases;
  localparam int L  = clog2_size_of_output_layer;
  localparam int RW = CW + 7;
  localparam logic [CW-1:0] LAST = CW'(number_of_test_cases - 1);
  localparam logic [RW-1:0] NR   = RW'(number_of_test_cases);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMP, S_DIV, S_DONE} state_t;

  state_t          r_state, w_next;
  logic            r_pv_d;
  logic [L-1:0]    r_pred_q;
  logic [CW-1:0]   r_index, r_correct, r_wrong;
  logic            r_mismatch, r_overrun, r_done;
  logic [RW-1:0]   r_rem;
  logic [6:0]      r_q, r_accuracy;

  logic            w_accept, w_eq, w_last, w_rem_ge;
  logic            w_capture, w_cmp, w_div_load, w_div_sub, w_div_end, w_drop;
  logic [CW-1:0]   w_correct_next;
  logic [RW-1:0]   w_c_ext, w_prod;

  assign w_accept       = pred_valid & ~r_pv_d & clk_en;
  assign w_eq           = (r_pred_q == exp_label);
  assign w_last         = (r_index == LAST);
  assign w_rem_ge       = (r_rem >= NR);
  assign w_correct_next = w_eq ? r_correct + CW'(1) : r_correct;
  // correct*100 without a multiplier: 64c + 32c + 4c
  assign w_c_ext        = {7'd0, w_correct_next};
  assign w_prod         = (w_c_ext << 6) + (w_c_ext << 5) + (w_c_ext << 2);

  always_ff @(posedge clk) begin
    if (!rst)        r_state <= S_IDLE;
    else if (clk_en) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_WAIT;
      S_WAIT: w_next = S_CMP;
      S_CMP:  w_next = w_last ? S_DIV : S_IDLE;
      S_DIV:  if (!w_rem_ge) w_next = S_DONE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture  = (r_state == S_IDLE) & w_accept;
    w_cmp      = (r_state == S_CMP);
    w_div_load = w_cmp & w_last;
    w_div_sub  = (r_state == S_DIV) & w_rem_ge;
    w_div_end  = (r_state == S_DIV) & ~w_rem_ge;
    w_drop     = w_accept & ((r_state == S_WAIT) | (r_state == S_CMP) | (r_state == S_DIV));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pv_d     <= 1'b0;
      r_pred_q   <= '0;
      r_index    <= '0;
      r_correct  <= '0;
      r_wrong    <= '0;
      r_mismatch <= 1'b0;
      r_overrun  <= 1'b0;
      r_rem      <= '0;
      r_q        <= '0;
      r_accuracy <= '0;
      r_done     <= 1'b0;
    end else if (clk_en) begin
      r_pv_d     <= pred_valid;
      r_mismatch <= w_cmp & ~w_eq;
      if (w_capture) r_pred_q <= pred_label;
      if (w_cmp) begin
        r_correct <= w_correct_next;
        if (!w_eq)  r_wrong <= r_wrong + CW'(1);
        if (!w_last) r_index <= r_index + CW'(1);
      end
      if (w_div_load) begin
        r_rem <= w_prod;
        r_q   <= '0;
      end
      if (w_div_sub) begin
        r_rem <= r_rem - NR;
        r_q   <= r_q + 7'd1;
      end
      if (w_div_end) begin
        r_accuracy <= r_q;
        r_done     <= 1'b1;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign exp_addr      = r_index;
  assign correct_count = r_correct;
  assign wrong_count   = r_wrong;
  assign mismatch      = r_mismatch;
  assign overrun       = r_overrun;
  assign accuracy      = r_accuracy;
  assign done          = r_done;
endmodule
